// File: rtl/dfe_mon_pkg.sv
// Shared types and helpers for the DFE stage monitor: capture FSM states,
// trigger modes, default geometry and a saturating counter step.
package dfe_mon_pkg;

  localparam int DFE_MON_DATA_WIDTH = 16;
  localparam int DFE_MON_N_STAGES   = 6;
  localparam int DFE_MON_DEPTH      = 64;
  localparam int DFE_MON_CNT_WIDTH  = 16;

  typedef enum logic [2:0] {
    MON_IDLE,
    MON_FILL,
    MON_ARMED,
    MON_POST,
    MON_DONE
  } mon_state_e;

  typedef enum logic [1:0] {
    TRIG_IMM,
    TRIG_OVF,
    TRIG_UNF,
    TRIG_MAG
  } trig_mode_e;

  // Increment v, holding at 2^w-1 (w must be below 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dfe_mon_capture_ram.sv
// Simple dual-port capture RAM: synchronous write, registered read.
module dfe_mon_capture_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dfe_stage_monitor.sv
// Per-stage live tap mux, saturating ovf/unf event counters and a
// pre/post-trigger circular snapshot of one selected DFE stage.
module dfe_stage_monitor
  import dfe_mon_pkg::*;
#(
  parameter int DATA_WIDTH = DFE_MON_DATA_WIDTH,
  parameter int N_STAGES   = DFE_MON_N_STAGES,
  parameter int DEPTH      = DFE_MON_DEPTH,
  parameter int CNT_WIDTH  = DFE_MON_CNT_WIDTH,
  parameter int SEL_W      = $clog2(N_STAGES),
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_STAGES*DATA_WIDTH-1:0] stage_data,
  input  logic [N_STAGES-1:0]            stage_valid,
  input  logic [N_STAGES-1:0]            stage_ovf,
  input  logic [N_STAGES-1:0]            stage_unf,
  input  logic [SEL_W-1:0]               sel,
  input  logic                           arm,
  input  logic [1:0]                     trig_mode,
  input  logic [DATA_WIDTH-2:0]          trig_thr,
  input  logic [AW:0]                    post_len,
  input  logic                           cnt_clr,
  input  logic [AW-1:0]                  rd_addr,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [CNT_WIDTH-1:0]           ovf_cnt,
  output logic [CNT_WIDTH-1:0]           unf_cnt,
  output logic [DATA_WIDTH-1:0]          block_out,
  output logic                           block_valid_out,
  output logic                           block_overflow,
  output logic                           block_underflow,
  output logic                           busy,
  output logic                           triggered,
  output logic                           done
);

  localparam int NSEL = 1 << SEL_W;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Taps padded to a power of two so any select value indexes safely;
  // out-of-range selects read as zero and never count or capture.
  logic signed [DATA_WIDTH-1:0] data_arr [NSEL];
  logic [NSEL-1:0]              valid_ext, ovf_ext, unf_ext;
  logic [CNT_WIDTH-1:0]         ovf_view [NSEL];
  logic [CNT_WIDTH-1:0]         unf_view [NSEL];
  logic [CNT_WIDTH-1:0]         ovf_ctr_q [N_STAGES];
  logic [CNT_WIDTH-1:0]         ovf_ctr_d [N_STAGES];
  logic [CNT_WIDTH-1:0]         unf_ctr_q [N_STAGES];
  logic [CNT_WIDTH-1:0]         unf_ctr_d [N_STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < NSEL; gi++) begin : g_tap
      if (gi < N_STAGES) begin : g_real
        assign data_arr[gi]  = stage_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign valid_ext[gi] = stage_valid[gi];
        assign ovf_ext[gi]   = stage_ovf[gi];
        assign unf_ext[gi]   = stage_unf[gi];
        assign ovf_view[gi]  = ovf_ctr_q[gi];
        assign unf_view[gi]  = unf_ctr_q[gi];
      end else begin : g_pad
        assign data_arr[gi]  = '0;
        assign valid_ext[gi] = 1'b0;
        assign ovf_ext[gi]   = 1'b0;
        assign unf_ext[gi]   = 1'b0;
        assign ovf_view[gi]  = '0;
        assign unf_view[gi]  = '0;
      end
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < N_STAGES; i++) begin
      ovf_ctr_d[i] = ovf_ctr_q[i];
      unf_ctr_d[i] = unf_ctr_q[i];
      if (cnt_clr) begin
        ovf_ctr_d[i] = '0;
        unf_ctr_d[i] = '0;
      end else begin
        if (stage_valid[i] && stage_ovf[i])
          ovf_ctr_d[i] = CNT_WIDTH'(sat_inc(32'(ovf_ctr_q[i]), CNT_WIDTH));
        if (stage_valid[i] && stage_unf[i])
          unf_ctr_d[i] = CNT_WIDTH'(sat_inc(32'(unf_ctr_q[i]), CNT_WIDTH));
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_STAGES; i++) begin
      if (rst) begin
        ovf_ctr_q[i] <= '0;
        unf_ctr_q[i] <= '0;
      end else begin
        ovf_ctr_q[i] <= ovf_ctr_d[i];
        unf_ctr_q[i] <= unf_ctr_d[i];
      end
    end
  end

  // Live outputs
  logic [DATA_WIDTH-1:0] block_out_q, block_out_d;
  logic                  bvalid_q, bvalid_d, bovf_q, bovf_d, bunf_q, bunf_d;
  logic [CNT_WIDTH-1:0]  ovf_cnt_q, ovf_cnt_d, unf_cnt_q, unf_cnt_d;

  always_comb begin
    block_out_d = data_arr[sel];
    bvalid_d    = valid_ext[sel];
    bovf_d      = ovf_ext[sel];
    bunf_d      = unf_ext[sel];
    ovf_cnt_d   = ovf_view[sel];
    unf_cnt_d   = unf_view[sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      block_out_q <= '0;
      bvalid_q    <= 1'b0;
      bovf_q      <= 1'b0;
      bunf_q      <= 1'b0;
      ovf_cnt_q   <= '0;
      unf_cnt_q   <= '0;
    end else begin
      block_out_q <= block_out_d;
      bvalid_q    <= bvalid_d;
      bovf_q      <= bovf_d;
      bunf_q      <= bunf_d;
      ovf_cnt_q   <= ovf_cnt_d;
      unf_cnt_q   <= unf_cnt_d;
    end
  end

  // Capture state
  mon_state_e            state_q, state_d;
  trig_mode_e            mode_q, mode_d;
  logic [SEL_W-1:0]      csel_q, csel_d;
  logic [DATA_WIDTH-2:0] thr_q, thr_d;
  logic [AW:0]           p_q, p_d, fill_q, fill_d, rem_q, rem_d, p_clamp;
  logic [AW-1:0]         wptr_q, wptr_d;
  logic                  trig_q, trig_d, rd_en_q, rd_en_d;
  logic                  we;

  logic signed [DATA_WIDTH-1:0] cur_sample, neg_sample;
  logic [DATA_WIDTH-2:0]        cur_mag;
  logic                         cur_valid, trig_hit;

  always_comb begin
    cur_sample = data_arr[csel_q];
    cur_valid  = valid_ext[csel_q];
    neg_sample = -cur_sample;
    if (cur_sample == MOST_NEG)
      cur_mag = '1;
    else if (cur_sample[DATA_WIDTH-1])
      cur_mag = neg_sample[DATA_WIDTH-2:0];
    else
      cur_mag = cur_sample[DATA_WIDTH-2:0];
    case (mode_q)
      TRIG_IMM: trig_hit = 1'b1;
      TRIG_OVF: trig_hit = ovf_ext[csel_q];
      TRIG_UNF: trig_hit = unf_ext[csel_q];
      TRIG_MAG: trig_hit = (cur_mag >= thr_q);
      default:  trig_hit = 1'b0;
    endcase
    if (post_len == '0)
      p_clamp = (AW+1)'(1);
    else if (post_len > DEPTH_C)
      p_clamp = DEPTH_C;
    else
      p_clamp = post_len;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    csel_d  = csel_q;
    thr_d   = thr_q;
    p_d     = p_q;
    fill_d  = fill_q;
    rem_d   = rem_q;
    wptr_d  = wptr_q;
    trig_d  = trig_q;
    we      = 1'b0;
    rd_en_d = (state_q == MON_DONE);
    if (arm) begin
      mode_d  = trig_mode_e'(trig_mode);
      csel_d  = sel;
      thr_d   = trig_thr;
      p_d     = p_clamp;
      fill_d  = '0;
      wptr_d  = '0;
      trig_d  = 1'b0;
      state_d = (p_clamp == DEPTH_C) ? MON_ARMED : MON_FILL;
    end else begin
      case (state_q)
        MON_FILL: if (cur_valid) begin
          we     = 1'b1;
          wptr_d = wptr_q + 1'b1;
          fill_d = fill_q + 1'b1;
          if (fill_d == DEPTH_C - p_q) state_d = MON_ARMED;
        end
        MON_ARMED: if (cur_valid) begin
          we     = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (trig_hit) begin
            trig_d  = 1'b1;
            rem_d   = p_q - (AW+1)'(1);
            state_d = (p_q == (AW+1)'(1)) ? MON_DONE : MON_POST;
          end
        end
        MON_POST: if (cur_valid) begin
          we     = 1'b1;
          wptr_d = wptr_q + 1'b1;
          rem_d  = rem_q - (AW+1)'(1);
          if (rem_q == (AW+1)'(1)) state_d = MON_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MON_IDLE;
      mode_q  <= TRIG_IMM;
      csel_q  <= '0;
      thr_q   <= '0;
      p_q     <= '0;
      fill_q  <= '0;
      rem_q   <= '0;
      wptr_q  <= '0;
      trig_q  <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      csel_q  <= csel_d;
      thr_q   <= thr_d;
      p_q     <= p_d;
      fill_q  <= fill_d;
      rem_q   <= rem_d;
      wptr_q  <= wptr_d;
      trig_q  <= trig_d;
      rd_en_q <= rd_en_d;
    end
  end

  logic [DATA_WIDTH-1:0] ram_rdata;

  // Once done the whole ring is written, so the oldest sample sits at wptr.
  dfe_mon_capture_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wptr_q),
    .wdata(cur_sample),
    .raddr(wptr_q + rd_addr),
    .rdata(ram_rdata)
  );

  assign rd_data         = rd_en_q ? ram_rdata : '0;
  assign ovf_cnt         = ovf_cnt_q;
  assign unf_cnt         = unf_cnt_q;
  assign block_out       = block_out_q;
  assign block_valid_out = bvalid_q;
  assign block_overflow  = bovf_q;
  assign block_underflow = bunf_q;
  assign busy            = (state_q == MON_FILL) || (state_q == MON_ARMED) || (state_q == MON_POST);
  assign triggered       = trig_q;
  assign done            = (state_q == MON_DONE);

endmodule

// File: tb/tb_dfe_stage_monitor.sv
// Scoreboard bench for dfe_stage_monitor with a small geometry
// (DEPTH=8, CNT_WIDTH=4) so saturation and ring wrap are reached quickly.
module tb_dfe_stage_monitor;

  localparam int DW  = 16;
  localparam int NS  = 6;
  localparam int DEP = 8;
  localparam int CW  = 4;
  localparam int SW  = 3;
  localparam int AW  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS*DW-1:0]  stage_data;
  logic [NS-1:0]     stage_valid, stage_ovf, stage_unf;
  logic [SW-1:0]     sel;
  logic              arm;
  logic [1:0]        trig_mode;
  logic [DW-2:0]     trig_thr;
  logic [AW:0]       post_len;
  logic              cnt_clr;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     rd_data, block_out;
  logic [CW-1:0]     ovf_cnt, unf_cnt;
  logic              block_valid_out, block_overflow, block_underflow;
  logic              busy, triggered, done;

  dfe_stage_monitor #(
    .DATA_WIDTH(DW), .N_STAGES(NS), .DEPTH(DEP), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .stage_data(stage_data), .stage_valid(stage_valid),
    .stage_ovf(stage_ovf), .stage_unf(stage_unf), .sel(sel), .arm(arm),
    .trig_mode(trig_mode), .trig_thr(trig_thr), .post_len(post_len),
    .cnt_clr(cnt_clr), .rd_addr(rd_addr), .rd_data(rd_data), .ovf_cnt(ovf_cnt),
    .unf_cnt(unf_cnt), .block_out(block_out), .block_valid_out(block_valid_out),
    .block_overflow(block_overflow), .block_underflow(block_underflow),
    .busy(busy), .triggered(triggered), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] hist[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, act);
    end
  endtask

  task automatic expect_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] act);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL scoreboard_empty: got %0h expected an entry", act);
    end else begin
      e = sb.pop_front();
      check(e.tag, act, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stages();
    stage_data  = '0;
    stage_valid = '0;
    stage_ovf   = '0;
    stage_unf   = '0;
  endtask

  task automatic arm_cap(input logic [SW-1:0] s, input logic [1:0] m,
                         input logic [DW-2:0] thr, input logic [AW:0] pl);
    sel       = s;
    trig_mode = m;
    trig_thr  = thr;
    post_len  = pl;
    arm       = 1'b1;
    tick();
    arm = 1'b0;
    hist.delete();
  endtask

  task automatic feed(input int s, input logic [15:0] v, input bit vld, input bit ov, input bit un);
    stage_data[s*DW +: DW] = v;
    stage_valid[s]         = vld;
    stage_ovf[s]           = ov;
    stage_unf[s]           = un;
    if (vld) hist.push_back(v);
    tick();
    clear_stages();
  endtask

  // The ring holds the last DEP samples written since arm, oldest first.
  task automatic readout(input string name);
    for (int i = 0; i < DEP; i++)
      expect_push($sformatf("%s_rd%0d", name, i), 32'(hist[hist.size() - DEP + i]));
    for (int i = 0; i < DEP; i++) begin
      rd_addr = AW'(i);
      tick();
      pop_check(32'(rd_data));
    end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; trig_mode = '0; trig_thr = '0; post_len = '0;
    cnt_clr = 1'b0; rd_addr = '0; sel = '0;
    clear_stages();
    tick(); tick();
    check("rst_block_out", 32'(block_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_trig", 32'(triggered), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_ovf_cnt", 32'(ovf_cnt), 0);
    rst = 1'b0;
    tick();

    // Live mux
    sel = 3'd2;
    stage_data[2*DW +: DW] = 16'h1234;
    stage_valid[2] = 1'b1;
    stage_unf[2]   = 1'b1;
    expect_push("live_out", 32'h1234);
    expect_push("live_valid", 1);
    expect_push("live_unf", 1);
    tick();
    pop_check(32'(block_out));
    pop_check(32'(block_valid_out));
    pop_check(32'(block_underflow));
    sel = 3'd7;
    stage_ovf[2] = 1'b1;
    expect_push("bad_sel_out", 0);
    expect_push("bad_sel_valid", 0);
    expect_push("bad_sel_ovf", 0);
    expect_push("bad_sel_unf", 0);
    tick();
    pop_check(32'(block_out));
    pop_check(32'(block_valid_out));
    pop_check(32'(block_overflow));
    pop_check(32'(block_underflow));
    clear_stages();
    tick();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;

    // Counters on stage 1
    sel = 3'd1;
    for (int i = 0; i < 5; i++) feed(1, 16'h0, 1'b1, 1'b1, 1'b0);
    expect_push("ovf_cnt_5", 5);
    tick();
    pop_check(32'(ovf_cnt));
    for (int i = 0; i < 15; i++) feed(1, 16'h0, 1'b1, 1'b1, 1'b0);
    feed(1, 16'h0, 1'b0, 1'b0, 1'b1);
    feed(1, 16'h0, 1'b1, 1'b0, 1'b1);
    expect_push("ovf_cnt_sat", 15);
    expect_push("unf_cnt_1", 1);
    tick();
    pop_check(32'(ovf_cnt));
    pop_check(32'(unf_cnt));
    sel = 3'd0;
    expect_push("ovf_cnt_stage0", 0);
    tick();
    pop_check(32'(ovf_cnt));
    sel = 3'd1;
    cnt_clr = 1'b1;
    feed(1, 16'h0, 1'b1, 1'b1, 1'b0);
    cnt_clr = 1'b0;
    expect_push("ovf_cnt_clr", 0);
    tick();
    pop_check(32'(ovf_cnt));

    // Immediate capture, ramp with one idle cycle mixed in
    arm_cap(3'd0, 2'd0, '0, 4'd3);
    check("imm_busy", 32'(busy), 1);
    check("imm_done0", 32'(done), 0);
    for (int i = 0; i < 7; i++) begin
      feed(0, 16'(i), 1'b1, 1'b0, 1'b0);
      if (i == 3) feed(0, 16'hdead, 1'b0, 1'b0, 1'b0);
    end
    check("imm_done_early", 32'(done), 0);
    feed(0, 16'd7, 1'b1, 1'b0, 1'b0);
    check("imm_done", 32'(done), 1);
    check("imm_busy_end", 32'(busy), 0);
    check("imm_trig", 32'(triggered), 1);
    readout("imm");

    // Magnitude trigger
    arm_cap(3'd0, 2'd3, 15'd1000, 4'd4);
    for (int i = 1; i <= 9; i++) feed(0, 16'(i * 10), 1'b1, 1'b0, 1'b0);
    check("mag_no_trig", 32'(triggered), 0);
    feed(0, 16'hFB50, 1'b1, 1'b0, 1'b0);
    check("mag_trig", 32'(triggered), 1);
    check("mag_busy", 32'(busy), 1);
    for (int i = 5; i <= 7; i++) feed(0, 16'(i), 1'b1, 1'b0, 1'b0);
    check("mag_done", 32'(done), 1);
    readout("mag");
    rd_addr = 3'd4;
    expect_push("mag_trig_sample", 32'hFB50);
    tick();
    pop_check(32'(rd_data));

    // Most negative sample, post_len 0 clamps to 1
    arm_cap(3'd0, 2'd3, 15'h7FFF, 4'd0);
    for (int i = 1; i <= 7; i++) feed(0, 16'(i), 1'b1, 1'b0, 1'b0);
    feed(0, 16'h7FFE, 1'b1, 1'b0, 1'b0);
    check("neg_not_yet", 32'(triggered), 0);
    feed(0, 16'h8000, 1'b1, 1'b0, 1'b0);
    check("neg_done", 32'(done), 1);
    readout("neg");

    // Overflow trigger ignored during FILL
    arm_cap(3'd0, 2'd1, '0, 4'd3);
    feed(0, 16'd100, 1'b1, 1'b0, 1'b0);
    feed(0, 16'd101, 1'b1, 1'b0, 1'b0);
    feed(0, 16'd102, 1'b1, 1'b1, 1'b0);
    check("fill_ignore", 32'(triggered), 0);
    feed(0, 16'd103, 1'b1, 1'b0, 1'b0);
    feed(0, 16'd104, 1'b1, 1'b0, 1'b0);
    feed(0, 16'd105, 1'b1, 1'b0, 1'b1);
    check("armed_no_ovf", 32'(triggered), 0);
    feed(0, 16'd106, 1'b1, 1'b1, 1'b0);
    check("armed_ovf", 32'(triggered), 1);
    feed(0, 16'd107, 1'b1, 1'b0, 1'b0);
    feed(0, 16'd108, 1'b1, 1'b0, 1'b0);
    check("ovf_done", 32'(done), 1);
    readout("ovf");

    // Invalid select latched: nothing is written, never completes
    arm_cap(3'd7, 2'd0, '0, 4'd1);
    for (int i = 0; i < 12; i++) feed(0, 16'(i), 1'b1, 1'b0, 1'b0);
    check("badsel_busy", 32'(busy), 1);
    check("badsel_done", 32'(done), 0);

    // Re-arm during POST restarts the capture
    arm_cap(3'd0, 2'd0, '0, 4'd3);
    for (int i = 0; i < 6; i++) feed(0, 16'(16'h200 + i), 1'b1, 1'b0, 1'b0);
    check("post_trig", 32'(triggered), 1);
    arm_cap(3'd0, 2'd0, '0, 4'd3);
    check("rearm_busy", 32'(busy), 1);
    check("rearm_done", 32'(done), 0);
    check("rearm_trig", 32'(triggered), 0);
    for (int i = 0; i < 5; i++) feed(0, 16'(16'h300 + i), 1'b1, 1'b0, 1'b0);
    check("rearm_fill_restart", 32'(triggered), 0);
    for (int i = 5; i < 8; i++) feed(0, 16'(16'h300 + i), 1'b1, 1'b0, 1'b0);
    check("rearm_done_end", 32'(done), 1);
    readout("rearm");

    // Reset in POST
    arm_cap(3'd0, 2'd1, '0, 4'd3);
    for (int i = 0; i < 5; i++) feed(0, 16'(i), 1'b1, 1'b1, 1'b0);
    feed(0, 16'h55, 1'b1, 1'b1, 1'b0);
    check("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_trig", 32'(triggered), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_block_valid", 32'(block_valid_out), 0);
    check("mid_rst_ovf_cnt", 32'(ovf_cnt), 0);
    check("mid_rst_rd_data", 32'(rd_data), 0);
    for (int i = 0; i < 10; i++) feed(0, 16'(i), 1'b1, 1'b0, 1'b0);
    check("idle_stays_idle", 32'(busy | done), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dfe_stage_monitor.md
Name: dfe_stage_monitor

Overview:
Parametrised observation and capture block for the DFE chain. It generalises the fixed stage-output/status selection into N_STAGES channels. Per stage it keeps saturating overflow/underflow event counters. It also provides a triggered snapshot buffer (pre/post-trigger circular capture) of one selected stage. It sits beside the filter core and is configured and read by the APB register file.

Parameters:
DATA_WIDTH, 16, sample width (signed)
N_STAGES, 6, number of monitored stage taps (frac-dec, IIR x3, CIC, core out)
DEPTH, 64, capture buffer depth in samples (power of two, >=4)
CNT_WIDTH, 16, width of each event counter
SEL_W, $clog2(N_STAGES), stage select width (derived)
AW, $clog2(DEPTH), buffer address width (derived)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stage_data  in  N_STAGES x DATA_WIDTH  signed stage outputs, packed, stage 0 in LSBs
stage_valid  in  N_STAGES  per-stage sample valid
stage_ovf  in  N_STAGES  per-stage overflow flag
stage_unf  in  N_STAGES  per-stage underflow flag
sel  in  SEL_W  stage select for live output and capture
arm  in  1  single-cycle pulse: start capture
trig_mode  in  2  0 immediate, 1 overflow, 2 underflow, 3 magnitude threshold
trig_thr  in  DATA_WIDTH-1  unsigned magnitude threshold
post_len  in  AW+1  samples captured from trigger (inclusive)
cnt_clr  in  1  clear all event counters
rd_addr  in  AW  logical read index, 0 = oldest captured sample
rd_data  out  DATA_WIDTH  capture read data
ovf_cnt  out  CNT_WIDTH  overflow count of stage sel
unf_cnt  out  CNT_WIDTH  underflow count of stage sel
block_out  out  DATA_WIDTH  live selected stage sample
block_valid_out / block_overflow / block_underflow  out  1 each  live selected flags
busy  out  1  capture in progress (FILL, ARMED, POST)
triggered  out  1  trigger accepted in current capture
done  out  1  capture complete, buffer readable

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, pointers 0. A reset mid-capture aborts it with done=0. Buffer contents after reset are don't-care.
- Live path: registered, 1-cycle latency. Sel >= N_STAGES drives zero on all block_* outputs.
- Counters: per stage, increment when stage_valid & flag. Saturate at 2^CNT_WIDTH-1. cnt_clr has priority over a same-cycle increment. ovf_cnt/unf_cnt are registered, reflecting counter values 1 cycle earlier.
- Capture FSM (package enum): IDLE, FILL, ARMED, POST, DONE.
- arm accepted in any state, and restarts capture when busy. On arm: latch sel, trig_mode, trig_thr, and P = clamp(post_len, 1, DEPTH). Set pre = DEPTH-P, wptr=0, fill=0, triggered=0, done=0. Go to FILL, or to ARMED if pre=0.
- Writes happen only on cycles where stage_valid[sel_q] is high: buf[wptr] <= sample, then wptr increments mod DEPTH.
- FILL: writes continue; move to ARMED once fill reaches pre. Triggers are ignored in FILL.
- ARMED: writes continue circularly. Trigger is evaluated on valid samples only:
  - mode 0: any valid sample
  - mode 1: stage_ovf
  - mode 2: stage_unf
  - mode 3: |sample| >= trig_thr, with the most negative value treated as 2^(DATA_WIDTH-1)-1
- On trigger: the trigger sample is written as post sample 1, triggered=1, and remaining = P-1. If P=1, go directly to DONE; else go to POST.
- POST: write remaining valid samples; after the last one, go to DONE.
- DONE: no writes; done=1, busy=0. Oldest sample is at start = wptr (the full buffer was written). rd_data = buf[(start+rd_addr) mod DEPTH], 1-cycle registered latency. rd_data=0 outside DONE.
- Invalid sel latched at arm: no writes occur; the FSM stays in FILL or ARMED until the next arm or reset.

Decomposition:
- Package dfe_mon_pkg: mon_state_e, trig_mode_e, counter saturation helper function, default-parameter constants.
- Sub-module dfe_mon_capture_ram: simple dual-port RAM, DEPTH x DATA_WIDTH, synchronous write, 1-cycle registered read.
- Counters and FSM stay in the top.

Test Plan:
- Live mux: sel=2, stage 2 sample 16'h1234 valid -> next cycle block_out=16'h1234, block_valid_out=1. Then sel=7 -> all block_* = 0.
- Counter saturation: CNT_WIDTH=4, 20 valid ovf pulses on stage 1 -> ovf_cnt=15. cnt_clr together with a pulse -> 0.
- Immediate capture: DEPTH=8, post_len=3, mode 0, ramp 0,1,2,... on stage 0, arm -> done after 8 valid samples. rd_addr 0..7 returns 0..7.
- Magnitude trigger: DEPTH=8, post_len=4, thr=1000, samples 10,20,...,90 then -1200 then 5,6,7 -> rd_addr 4 = -1200; rd_addr 0..3 = 60,70,80,90; rd_addr 5..7 = 5,6,7.
- Trigger during FILL ignored: ovf pulse at fill=2 with pre=5 -> triggered stays 0; next ovf in ARMED is accepted.
- Abort/reset: re-arm during POST -> busy=1, done=0, fill restarts. rst mid-POST -> next cycle all outputs 0, state IDLE.
